// File: rtl/mode_switch_if.sv
// Mode request handshake between the host/CSR side and mode_switch_ctrl.
interface mode_switch_if;
  logic       req_valid;
  logic [2:0] req_mode;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_mode,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_mode,
    output req_ready
  );
endinterface

// File: rtl/mode_switch_ctrl.sv
// Video mode change sequencer: applies mode requests at frame boundaries with blanking and timing hold.
// Optional frame_end watchdog enabled by defining MODE_SWITCH_TIMEOUT_EN.
module mode_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned BLANK_FRAMES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  mode_switch_if.slave     req,
  input  logic             frame_end,
  output logic [2:0]       lut_mode,
  output logic             mode_change,
  output logic             tg_hold,
  output logic             blank,
  output logic [2:0]       cur_mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             timeout
);

  localparam int unsigned SW         = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned FW         = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam int unsigned LAST_FRAME = (BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0;
  localparam logic [2:0]  MODE_LIMIT = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    APPLY,
    SETTLE,
    UNBLANK,
    DONE
  } state_t;

  state_t        state;
  logic          ready_q;
  logic          pend_valid;
  logic [2:0]    pend_mode;
  logic [SW-1:0] settle_cnt;
  logic [FW-1:0] frame_cnt;

  logic          accept;
  logic          store;
  logic          pop;
  logic          chk_en;
  logic [2:0]    chk_mode;
  logic          frame_ev;

  assign req.req_ready = ready_q;
  assign accept        = req.req_valid & ready_q;

  // A request is checked straight from the bus in IDLE, otherwise from the pending slot.
  always_comb begin
    chk_en   = 1'b0;
    chk_mode = pend_valid ? pend_mode : req.req_mode;
    if (state == IDLE)
      chk_en = pend_valid | accept;
    else if (state == DONE)
      chk_en = pend_valid;
  end

  assign pop   = chk_en & pend_valid;
  assign store = accept & (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_mode  <= '0;
      ready_q    <= 1'b1;
    end else begin
      if (store) begin
        pend_valid <= 1'b1;
        pend_mode  <= req.req_mode;
      end else if (pop) begin
        pend_valid <= 1'b0;
      end
      ready_q <= !(store | (pend_valid & !pop));
    end
  end

`ifdef MODE_SWITCH_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_cnt;

  // The registered timeout pulse stands in for the missing frame_end one cycle later.
  assign frame_ev = frame_end | timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!((state == WAIT_FRAME) || (state == UNBLANK)) || frame_ev) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
        wd_cnt  <= '0;
        timeout <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + WW'(1);
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign frame_ev           = frame_end;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lut_mode    <= '0;
      cur_mode    <= '0;
      mode_change <= 1'b0;
      tg_hold     <= 1'b0;
      blank       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      settle_cnt  <= '0;
      frame_cnt   <= '0;
    end else begin
      mode_change <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;

      case (state)
        IDLE, DONE: begin
          blank   <= 1'b0;
          tg_hold <= 1'b0;
          if (chk_en && (chk_mode >= MODE_LIMIT)) begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (chk_en && (chk_mode == cur_mode)) begin
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (chk_en) begin
            lut_mode <= chk_mode;
            state    <= WAIT_FRAME;
            busy     <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        WAIT_FRAME: begin
          blank <= 1'b0;
          if (frame_ev) begin
            state       <= APPLY;
            mode_change <= 1'b1;
            blank       <= 1'b1;
          end
        end

        APPLY: begin
          state      <= SETTLE;
          tg_hold    <= 1'b1;
          blank      <= 1'b1;
          settle_cnt <= SW'(1);
        end

        SETTLE: begin
          if (settle_cnt >= SW'(SETTLE_CYCLES)) begin
            tg_hold   <= 1'b0;
            frame_cnt <= '0;
            if (BLANK_FRAMES > 0) begin
              state <= UNBLANK;
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              blank    <= 1'b0;
              cur_mode <= lut_mode;
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        UNBLANK: begin
          if (frame_ev) begin
            if (frame_cnt == FW'(LAST_FRAME)) begin
              state    <= DONE;
              done     <= 1'b1;
              blank    <= 1'b0;
              cur_mode <= lut_mode;
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          blank <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mode_switch_ctrl.md
Name: mode_switch_ctrl

Overview:
- Sequences video mode changes for the video pattern generator's mode lookup table and timing generator.
- Accepts mode requests from the host/CSR side over a valid/ready handshake, with one pending slot.
- Changes mode only at a frame boundary: blanks video, pulses the LUT load strobe, and holds the timing generator while the new timing settles.
- Releases video after a programmable number of blank frames.

Parameters:
- SETTLE_CYCLES, 16: cycles tg_hold stays high after the LUT load strobe (min 1).
- BLANK_FRAMES, 2: frame_end pulses counted with blank high after tg_hold drops; 0 skips this phase.
- TIMEOUT_CYCLES, 2000000: watchdog limit for waiting on frame_end (used only with the optional feature).

Ports:
- clk  in  1  pixel-domain clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  mode request valid.
- req_mode  in  3  requested mode; codes 0-5 per project mode defines, 6-7 illegal.
- req_ready  out  1  request slot free.
- frame_end  in  1  one-cycle pulse from timing generator at last pixel of frame.
- lut_mode  out  3  mode bus to mode LUT; stable whenever mode_change is high.
- mode_change  out  1  one-cycle LUT load strobe.
- tg_hold  out  1  holds timing generator counters in reset.
- blank  out  1  forces pixel output to black.
- cur_mode  out  3  last successfully applied mode.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a sequence completes or a same-mode request is acknowledged.
- err  out  1  one-cycle pulse on an illegal mode request.
- timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset: state=IDLE; lut_mode=0, cur_mode=0, pending empty.
- Reset: mode_change, tg_hold, blank, done, err, timeout, busy = 0; req_ready=1.
- All outputs are registered. Reset mid-sequence aborts immediately to these values; the LUT keeps its last loaded timing.
- Handshake:
  - Accept on req_valid & req_ready.
  - req_ready = !pending_valid.
  - In IDLE an accepted request is consumed directly. In any other state it is stored in the pending slot; the slot holds one entry.
  - req_ready stays low while the slot is full; requests are never dropped once accepted.
- Request check, one cycle after accept (or when pending is popped):
  - req_mode >= 6: err pulse, no state change, request discarded.
  - req_mode == cur_mode: done pulse, no sequence.
  - Otherwise: lut_mode <= req_mode, go to WAIT_FRAME.
- WAIT_FRAME: blank=0. Sampling frame_end=1 in cycle t enters APPLY at t+1.
- APPLY (1 cycle): mode_change=1, blank=1. Next state SETTLE.
- SETTLE: tg_hold=1, blank=1 for exactly SETTLE_CYCLES cycles, then:
  - UNBLANK if BLANK_FRAMES > 0;
  - DONE if BLANK_FRAMES = 0.
- UNBLANK: tg_hold=0, blank=1. Counts frame_end pulses; on the BLANK_FRAMES-th pulse, goes to DONE.
- DONE (1 cycle): done=1, cur_mode <= lut_mode, blank=0.
  - Next state: pending valid -> pop it and run the request check; else IDLE.
- Latency example (SETTLE_CYCLES=16): frame_end at t -> mode_change at t+1 -> tg_hold high t+2..t+17 -> UNBLANK from t+18.
- Simultaneous events:
  - Accept and pop in the same cycle: the slot stays full with the new entry.
  - frame_end while in SETTLE is ignored, not counted.
  - frame_end on the cycle of entering UNBLANK is not counted.
- Counter widths: clog2(max param + 1). The settle counter saturates and never wraps.

Optional Feature:
- Macro: MODE_SWITCH_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_FRAME and UNBLANK, cleared on every frame_end and on state entry.
  - On reaching TIMEOUT_CYCLES: timeout pulse, and the FSM proceeds as if frame_end had arrived (WAIT_FRAME -> APPLY; in UNBLANK the pulse counts as one frame).
- Undefined: no watchdog logic; timeout tied to 0; the FSM waits on frame_end indefinitely.

Test Plan:
- Reset then idle 10 cycles -> cur_mode=0, req_ready=1, blank=0, tg_hold=0, busy=0.
- Request mode 2, frame_end at cycle 50 -> mode_change high only cycle 51 with lut_mode=2; tg_hold cycles 52-67; blank cycles 51 through DONE; after 2 further frame_end pulses, done=1 and cur_mode=2.
- Request 2 in progress, request 4 and then 5 -> 4 accepted into pending, req_ready low so 5 stalls; after done for 2, a second sequence runs for 4 without returning to IDLE.
- Request mode 7 -> err pulse, cur_mode unchanged, busy stays 0. Request current mode -> done pulse, no mode_change.
- Assert reset during SETTLE -> next cycle tg_hold=0, blank=0, busy=0, pending cleared, cur_mode=0.
- With MODE_SWITCH_TIMEOUT_EN, TIMEOUT_CYCLES=100, no frame_end -> timeout pulse at 100 cycles in WAIT_FRAME, mode_change the next cycle. Without the macro -> FSM stays in WAIT_FRAME and timeout stays 0.
